// File: rtl/alu_pipe.sv
// Two-stage pipelined signed ALU with valid/ready handshake and a delivered-result counter.
// Optional clamping of arithmetic results and the sat output are enabled by defining ALU_SAT_EN.
module alu_pipe #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ALU_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic                    a_en,
    input  logic [2:0]              a_op,
    input  logic                    b_en,
    input  logic [1:0]              b_op,
    output logic                    C_en,
    input  logic                    C_ready,
    output logic signed [WIDTH:0]   C,
    output logic                    err,
    output logic [CNT_W-1:0]        count
`ifdef ALU_SAT_EN
    ,
    output logic                    sat
`endif
);

    localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);
`ifdef ALU_SAT_EN
    localparam logic [WIDTH:0] SAT_MAX = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0] SAT_MIN = {2'b11, {(WIDTH-1){1'b0}}};
`endif

    logic                    r_s1Valid;
    logic [WIDTH-1:0]        r_s1A;
    logic [WIDTH-1:0]        r_s1B;
    logic                    r_s1AEn;
    logic [2:0]              r_s1AOp;
    logic                    r_s1BEn;
    logic [1:0]              r_s1BOp;

    logic                    r_s2Valid;
    logic [WIDTH:0]          r_s2C;
    logic                    r_s2Err;
`ifdef ALU_SAT_EN
    logic                    r_s2Sat;
`endif
    logic [CNT_W-1:0]        r_count;

    logic                    w_adv;
    logic                    w_bankA;
    logic                    w_bankB;
    logic [WIDTH:0]          w_extA;
    logic [WIDTH:0]          w_extB;
    logic [WIDTH-1:0]        w_logic;
    logic [WIDTH:0]          w_res;
    logic                    w_err;
    logic [WIDTH:0]          w_final;
`ifdef ALU_SAT_EN
    logic                    w_arith;
    logic                    w_ovf;
`endif

    // The whole pipeline moves together; stalls come only from ALU_en or a blocked output.
    assign w_adv    = ALU_en && (!r_s2Valid || C_ready);
    assign in_ready = w_adv;

    assign w_bankA = r_s1AEn && !r_s1BEn;
    assign w_bankB = r_s1BEn && !r_s1AEn;
    assign w_extA  = {r_s1A[WIDTH-1], r_s1A};
    assign w_extB  = {r_s1B[WIDTH-1], r_s1B};

    always_comb begin
        w_logic = '0;
        w_res   = '0;
        w_err   = 1'b0;
        if (w_bankA) begin
            case (r_s1AOp)
                3'd0:    w_res = w_extA + w_extB;
                3'd1:    w_res = w_extA - w_extB;
                3'd2:    w_logic = r_s1A ^ r_s1B;
                3'd3:    w_logic = r_s1A & r_s1B;
                3'd4:    w_logic = r_s1A | r_s1B;
                3'd5:    w_logic = ~(r_s1A ^ r_s1B);
                default: w_err = 1'b1;
            endcase
            if (r_s1AOp >= 3'd2 && r_s1AOp <= 3'd5) begin
                w_res = {w_logic[WIDTH-1], w_logic};
            end
        end else if (w_bankB) begin
            case (r_s1BOp)
                2'd0:    w_logic = ~(r_s1A & r_s1B);
                2'd1:    w_logic = ~(r_s1A | r_s1B);
                2'd2:    w_res = w_extA + ONE;
                default: w_res = w_extB - ONE;
            endcase
            if (r_s1BOp <= 2'd1) begin
                w_res = {w_logic[WIDTH-1], w_logic};
            end
        end else begin
            w_err = 1'b1;
        end
    end

`ifdef ALU_SAT_EN
    // A WIDTH+1 arithmetic result fits in WIDTH bits exactly when its top two bits agree.
    assign w_arith = (w_bankA && (r_s1AOp == 3'd0 || r_s1AOp == 3'd1)) ||
                     (w_bankB && (r_s1BOp == 2'd2 || r_s1BOp == 2'd3));
    assign w_ovf   = w_arith && (w_res[WIDTH] != w_res[WIDTH-1]);
    assign w_final = w_err ? '0 : (w_ovf ? (w_res[WIDTH] ? SAT_MIN : SAT_MAX) : w_res);
`else
    assign w_final = w_err ? '0 : w_res;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1A     <= '0;
            r_s1B     <= '0;
            r_s1AEn   <= 1'b0;
            r_s1AOp   <= '0;
            r_s1BEn   <= 1'b0;
            r_s1BOp   <= '0;
            r_s2Valid <= 1'b0;
            r_s2C     <= '0;
            r_s2Err   <= 1'b0;
`ifdef ALU_SAT_EN
            r_s2Sat   <= 1'b0;
`endif
        end else if (w_adv) begin
            r_s1Valid <= in_valid;
            r_s1A     <= A;
            r_s1B     <= B;
            r_s1AEn   <= a_en;
            r_s1AOp   <= a_op;
            r_s1BEn   <= b_en;
            r_s1BOp   <= b_op;
            r_s2Valid <= r_s1Valid;
            r_s2C     <= w_final;
            r_s2Err   <= w_err;
`ifdef ALU_SAT_EN
            r_s2Sat   <= w_ovf && !w_err;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (C_en && C_ready) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Output qualifiers are gated by ALU_en so a disabled block presents nothing.
    assign C_en  = ALU_en && r_s2Valid;
    assign C     = ALU_en ? r_s2C : '0;
    assign err   = ALU_en && r_s2Err;
    assign count = r_count;
`ifdef ALU_SAT_EN
    assign sat   = ALU_en && r_s2Sat;
`endif

endmodule
